// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: push handshake, register file drain port,
// bypass lookups and occupancy status.
interface wb_write_queue_if #(
    parameter int n     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [4:0]    in_addr;
    logic [n-1:0]  in_data;
    logic          in_ready;

    logic          drain_en;
    logic [4:0]    rf_write;
    logic [n-1:0]  rf_write_data;
    logic          rf_regWrite;

    logic          flush;

    logic [4:0]    lk_addr_1;
    logic [4:0]    lk_addr_2;
    logic          lk_hit_1;
    logic          lk_hit_2;
    logic [n-1:0]  lk_data_1;
    logic [n-1:0]  lk_data_2;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output in_valid, in_addr, in_data, drain_en, flush, lk_addr_1, lk_addr_2,
        input  in_ready, rf_write, rf_write_data, rf_regWrite,
               lk_hit_1, lk_hit_2, lk_data_1, lk_data_2, count, empty, full
    );

    modport slave (
        input  in_valid, in_addr, in_data, drain_en, flush, lk_addr_1, lk_addr_2,
        output in_ready, rf_write, rf_write_data, rf_regWrite,
               lk_hit_1, lk_hit_2, lk_data_1, lk_data_2, count, empty, full
    );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back FIFO between datapath and register file write port, with
// youngest-match bypass lookups over the pending entries.
module wb_write_queue #(
    parameter int n     = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [n-1:0]  data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          is_empty;
    logic          is_full;
    logic          push;
    logic          push_eff;
    logic          pop;
    logic [PW-1:0] idx;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign push     = bus.in_valid & ~is_full;
    // Writes to x0 finish the handshake but are never queued.
    assign push_eff = push & (bus.in_addr != 5'd0);
    assign pop      = ~is_empty & bus.drain_en;

    assign bus.in_ready      = ~is_full;
    assign bus.rf_regWrite   = pop;
    assign bus.rf_write      = is_empty ? 5'd0 : addr_mem[head];
    assign bus.rf_write_data = is_empty ? '0 : data_mem[head];
    assign bus.count         = cnt;
    assign bus.empty         = is_empty;
    assign bus.full          = is_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_eff) tail <= tail + 1'b1;
            if (pop)      head <= head + 1'b1;
            cnt <= cnt + CW'(push_eff) - CW'(pop);
        end
    end

    // Payload storage needs no reset: validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push_eff && !bus.flush) begin
            addr_mem[tail] <= bus.in_addr;
            data_mem[tail] <= bus.in_data;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        bus.lk_hit_1  = 1'b0;
        bus.lk_data_1 = '0;
        bus.lk_hit_2  = 1'b0;
        bus.lk_data_2 = '0;
        idx           = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + k[PW-1:0];
            if (k < int'(cnt)) begin
                if (bus.lk_addr_1 != 5'd0 && addr_mem[idx] == bus.lk_addr_1) begin
                    bus.lk_hit_1  = 1'b1;
                    bus.lk_data_1 = data_mem[idx];
                end
                if (bus.lk_addr_2 != 5'd0 && addr_mem[idx] == bus.lk_addr_2) begin
                    bus.lk_hit_2  = 1'b1;
                    bus.lk_data_2 = data_mem[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_wb_write_queue;
    localparam int n     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [4:0]   addr;
        logic [n-1:0] data;
    } entry_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    entry_t       mq[$];
    logic [4:0]   obs_addr[$];
    logic [n-1:0] obs_data[$];

    wb_write_queue_if #(.n(n), .DEPTH(DEPTH)) bus ();

    wb_write_queue #(.n(n), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Youngest matching pending entry, scanning the model queue oldest first.
    function automatic void m_lookup(input logic [4:0] a, output logic hit, output logic [n-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].addr == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
        end
    endfunction

    function automatic void model_step();
        int   sz;
        logic do_pop;
        logic do_push;
        sz      = mq.size();
        do_pop  = (sz > 0) && bus.drain_en;
        do_push = bus.in_valid && (sz < DEPTH) && (bus.in_addr != 5'd0);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{addr: bus.in_addr, data: bus.in_data});
        end
    endfunction

    task automatic drive(input logic v, input logic [4:0] a, input logic [n-1:0] d,
                         input logic dr, input logic fl);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.drain_en = dr;
        bus.flush    = fl;
    endtask

    // One clock: drive, record any register file write, advance the model.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [n-1:0] d,
                         input logic dr, input logic fl);
        drive(v, a, d, dr, fl);
        @(negedge clk);
        if (bus.rf_regWrite === 1'b1) begin
            obs_addr.push_back(bus.rf_write);
            obs_data.push_back(bus.rf_write_data);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 1'b0);
        bus.lk_addr_1 = 5'd5;
        bus.lk_addr_2 = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.empty !== 1'b1 || bus.count !== CW'(0) || bus.in_ready !== 1'b1 ||
                bus.rf_regWrite !== 1'b0 || bus.lk_hit_1 !== 1'b0 || bus.full !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state cyc=%0d: empty=%b count=%0d ready=%b regWrite=%b hit=%b full=%b, required 1 0 1 0 0 0",
                         i, bus.empty, bus.count, bus.in_ready, bus.rf_regWrite, bus.lk_hit_1, bus.full);
            end
        end
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        mq.delete();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== CW'(0)) begin
            errors++;
            $display("[TB] FAIL reset_release: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'(i), 32'(i * 'h11), 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== CW'(4)) begin
            errors++;
            $display("[TB] FAIL fill_full: full=%b ready=%b count=%0d, required 1 0 4",
                     bus.full, bus.in_ready, bus.count);
        end
        cycle(1'b1, 5'd5, 32'h55, 1'b0, 1'b0);
        checks++;
        if (bus.count !== CW'(4) || bus.rf_write !== 5'd1 || bus.rf_write_data !== 32'h11) begin
            errors++;
            $display("[TB] FAIL fill_stall: count=%0d head=%0d data=%h, required 4 1 11",
                     bus.count, bus.rf_write, bus.rf_write_data);
        end
    endtask

    task automatic test_ordered_drain();
        logic [4:0]   exp_a[5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        logic [n-1:0] exp_d[5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h66};
        obs_addr.delete();
        obs_data.delete();
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 5) begin
            errors++;
            $display("[TB] FAIL drain_len: got %0d writes, required 5", obs_addr.size());
        end
        for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_a[i] || obs_data[i] !== exp_d[i]) begin
                errors++;
                $display("[TB] FAIL drain_order[%0d]: got %0d/%h, required %0d/%h",
                         i, obs_addr[i], obs_data[i], exp_a[i], exp_d[i]);
            end
        end
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_empty: count=%0d empty=%b, required 0 1", bus.count, bus.empty);
        end
    endtask

    task automatic test_bypass();
        bus.lk_addr_1 = 5'd3;
        bus.lk_addr_2 = 5'd0;
        cycle(1'b1, 5'd3, 32'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 5'd3, 32'hBBBB, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.lk_hit_1 !== 1'b1 || bus.lk_data_1 !== 32'hBBBB) begin
            errors++;
            $display("[TB] FAIL bypass_youngest: hit=%b data=%h, required 1 0000bbbb", bus.lk_hit_1, bus.lk_data_1);
        end
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.lk_hit_2 !== 1'b0 || bus.lk_data_2 !== '0 || bus.count !== CW'(2)) begin
            errors++;
            $display("[TB] FAIL bypass_x0: hit=%b data=%h count=%0d, required 0 0 2",
                     bus.lk_hit_2, bus.lk_data_2, bus.count);
        end
        bus.lk_addr_2 = 5'd9;
        #1;
        checks++;
        if (bus.lk_hit_2 !== 1'b0 || bus.lk_data_2 !== '0) begin
            errors++;
            $display("[TB] FAIL bypass_miss: hit=%b data=%h, required 0 0", bus.lk_hit_2, bus.lk_data_2);
        end
    endtask

    task automatic test_x0_push_pop();
        obs_addr.delete();
        obs_data.delete();
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 1'b0);
        checks++;
        if (bus.count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL x0_poppush: count=%0d, required 1", bus.count);
        end
        cycle(1'b1, 5'd8, 32'h88, 1'b1, 1'b0);
        checks++;
        if (bus.count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL push_pop_same: count=%0d, required 1", bus.count);
        end
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 3 || obs_addr[obs_addr.size()-1] !== 5'd8 ||
            obs_data[obs_data.size()-1] !== 32'h88) begin
            errors++;
            $display("[TB] FAIL x0_drains: %0d writes, last addr=%0d, required 3 writes ending at 8",
                     obs_addr.size(), obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : 5'd0);
        end
        foreach (obs_addr[i]) begin
            checks++;
            if (obs_addr[i] === 5'd0) begin
                errors++;
                $display("[TB] FAIL x0_write[%0d]: got addr 0, required nonzero", i);
            end
        end
    endtask

    task automatic test_flush_and_reset();
        cycle(1'b1, 5'd10, 32'hA0, 1'b0, 1'b0);
        cycle(1'b1, 5'd11, 32'hB0, 1'b0, 1'b0);
        cycle(1'b1, 5'd12, 32'hC0, 1'b0, 1'b0);
        cycle(1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.count !== CW'(0) || bus.empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_count: count=%0d empty=%b, required 0 1", bus.count, bus.empty);
        end
        obs_addr.delete();
        obs_data.delete();
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_addr.size() != 0) begin
            errors++;
            $display("[TB] FAIL flush_drain: got %0d writes, required 0", obs_addr.size());
        end
        cycle(1'b1, 5'd20, 32'h2020, 1'b0, 1'b0);
        cycle(1'b1, 5'd21, 32'h2121, 1'b0, 1'b0);
        drive(1'b0, 5'd0, '0, 1'b1, 1'b0);
        #3;
        checks++;
        if (bus.rf_regWrite !== 1'b1 || bus.rf_write !== 5'd20) begin
            errors++;
            $display("[TB] FAIL pre_reset_drain: regWrite=%b addr=%0d, required 1 20", bus.rf_regWrite, bus.rf_write);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rf_regWrite !== 1'b0 || bus.count !== CW'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset: regWrite=%b count=%0d, required 0 0", bus.rf_regWrite, bus.count);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic         eh1, eh2;
        logic [n-1:0] ed1, ed2;
        int           sz;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
            bus.lk_addr_1 = 5'($urandom_range(0, 7));
            bus.lk_addr_2 = 5'($urandom_range(0, 7));
            @(negedge clk);
            sz = mq.size();
            m_lookup(bus.lk_addr_1, eh1, ed1);
            m_lookup(bus.lk_addr_2, eh2, ed2);
            checks++;
            if (bus.count !== CW'(sz) || bus.empty !== (sz == 0) || bus.full !== (sz == DEPTH) ||
                bus.in_ready !== (sz < DEPTH)) begin
                errors++;
                $display("[TB] FAIL rnd_status c=%0d: count=%0d empty=%b full=%b ready=%b, required count=%0d",
                         c, bus.count, bus.empty, bus.full, bus.in_ready, sz);
            end
            checks++;
            if (bus.rf_regWrite !== (sz > 0 && bus.drain_en) ||
                bus.rf_write !== (sz > 0 ? mq[0].addr : 5'd0) ||
                bus.rf_write_data !== (sz > 0 ? mq[0].data : '0)) begin
                errors++;
                $display("[TB] FAIL rnd_head c=%0d: regWrite=%b addr=%0d data=%h, required addr=%0d data=%h",
                         c, bus.rf_regWrite, bus.rf_write, bus.rf_write_data,
                         sz > 0 ? mq[0].addr : 5'd0, sz > 0 ? mq[0].data : '0);
            end
            checks++;
            if (bus.lk_hit_1 !== eh1 || bus.lk_data_1 !== ed1 || bus.lk_hit_2 !== eh2 || bus.lk_data_2 !== ed2) begin
                errors++;
                $display("[TB] FAIL rnd_bypass c=%0d: got %b/%h %b/%h, required %b/%h %b/%h",
                         c, bus.lk_hit_1, bus.lk_data_1, bus.lk_hit_2, bus.lk_data_2, eh1, ed1, eh2, ed2);
            end
            model_step();
            @(posedge clk);
            #1;
        end
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 1'b0);
        bus.lk_addr_1 = 5'd0;
        bus.lk_addr_2 = 5'd0;
        test_reset();
        test_fill_stall();
        test_ordered_drain();
        test_bypass();
        test_x0_push_pop();
        test_flush_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
